// File: rtl/relax_unit_if.sv
// Edge-cache query channel and distance-table port bundle used by relax_unit.
// master = relax_unit, slave = edge cache / distance table side.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 8
`endif

interface relax_unit_if #(
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
);
    logic                   query_enable;
    logic [INDEX_WIDTH-1:0] from_node;
    logic [INDEX_WIDTH-1:0] to_node;
    logic                   edge_ready;
    logic [VALUE_WIDTH-1:0] edge_value;

    logic [INDEX_WIDTH-1:0] dist_addr;
    logic [VALUE_WIDTH-1:0] dist_rd_data;
    logic                   visited_rd;
    logic                   dist_wr_en;
    logic [VALUE_WIDTH-1:0] dist_wr_data;
    logic [INDEX_WIDTH-1:0] prev_wr_data;

    modport master (
        output query_enable, from_node, to_node,
        input  edge_ready, edge_value,
        output dist_addr,
        input  dist_rd_data, visited_rd,
        output dist_wr_en, dist_wr_data, prev_wr_data
    );

    modport slave (
        input  query_enable, from_node, to_node,
        output edge_ready, edge_value,
        input  dist_addr,
        output dist_rd_data, visited_rd,
        input  dist_wr_en, dist_wr_data, prev_wr_data
    );
endinterface

// File: rtl/relax_unit.sv
// Relaxes every neighbour v of one settled node u: queries w(u,v) from the edge
// cache and writes dist[v] = dist[u] + w, prev[v] = u when that is a strict improvement.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 8
`endif

module relax_unit #(
    parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] current_node,
    input  logic [VALUE_WIDTH-1:0] current_dist,
    relax_unit_if.master           bus,
    output logic                   busy,
    output logic                   done,
    output logic [INDEX_WIDTH-1:0] updates
);
    typedef enum logic [2:0] {
        IDLE, SELECT, QUERY, COMPARE, NEXT, FINISH
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_SLOT = INDEX_WIDTH'(MAX_NODES - 1);
    localparam logic [INDEX_WIDTH-1:0] ONE       = INDEX_WIDTH'(1);

    state_t                 state, state_next;
    logic [INDEX_WIDTH-1:0] u_q, n_q, v_q, updates_q;
    logic [VALUE_WIDTH-1:0] du_q, w_q;
    logic [VALUE_WIDTH:0]   sum;
    logic                   improve;
    logic                   last_v;

    // The carry bit catches dist[u] + w overflowing past the representable range.
    assign sum     = {1'b0, du_q} + {1'b0, w_q};
    assign improve = (w_q != '0) && !bus.visited_rd && (du_q != '1) &&
                     !sum[VALUE_WIDTH] && (sum[VALUE_WIDTH-1:0] < bus.dist_rd_data);
    assign last_v  = (v_q == n_q - ONE) || (v_q == LAST_SLOT);

    // NOTE: reset is synchronous, so it is tested inside the clocked block rather than listed in the sensitivity list.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            u_q       <= '0;
            n_q       <= '0;
            v_q       <= '0;
            du_q      <= '0;
            w_q       <= '0;
            updates_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    u_q       <= current_node;
                    du_q      <= current_dist;
                    n_q       <= number_of_nodes;
                    v_q       <= '0;
                    updates_q <= '0;
                end
                QUERY:   if (bus.edge_ready) w_q <= bus.edge_value;
                COMPARE: if (improve) updates_q <= updates_q + ONE;
                NEXT:    if (!last_v) v_q <= v_q + ONE;
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next       = state;
        bus.query_enable = 1'b0;
        bus.dist_wr_en   = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        case (state)
            IDLE: if (start) state_next = (number_of_nodes == '0) ? FINISH : SELECT;
            SELECT: begin
                busy       = 1'b1;
                state_next = (v_q == u_q) ? NEXT : QUERY;
            end
            QUERY: begin
                busy             = 1'b1;
                bus.query_enable = 1'b1;
                if (bus.edge_ready) state_next = COMPARE;
            end
            COMPARE: begin
                busy           = 1'b1;
                bus.dist_wr_en = improve;
                state_next     = NEXT;
            end
            NEXT: begin
                busy       = 1'b1;
                state_next = last_v ? FINISH : SELECT;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.from_node    = u_q;
    assign bus.to_node      = v_q;
    assign bus.dist_addr    = v_q;
    assign bus.dist_wr_data = sum[VALUE_WIDTH-1:0];
    assign bus.prev_wr_data = u_q;
    assign updates          = updates_q;
endmodule

// File: doc/relax_unit.md
Name: relax_unit

Overview:
- Downstream consumer of the edge cache. For one settled node `u`, it walks every candidate neighbour `v` in the range 0..number_of_nodes-1.
- For each `v` it queries the edge cache for weight w(u,v) and reads the tentative distance table. It writes back `dist[v] = dist[u] + w` and `prev[v] = u` whenever that improves an unvisited node.
- The top-level Dijkstra controller drives it once per settled node and waits for `done`.

Parameters:
- MAX_NODES, `DEFAULT_MAX_NODES, capacity of the distance table.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, width of node indices.
- VALUE_WIDTH, `DEFAULT_VALUE_WIDTH, width of edge weights and distances. All-ones means infinity.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- number_of_nodes  in  INDEX_WIDTH  node count. Sampled on start.
- start  in  1  one-cycle pulse that begins relaxation. Ignored unless in IDLE.
- current_node  in  INDEX_WIDTH  `u`. Sampled on start.
- current_dist  in  VALUE_WIDTH  `dist[u]`. Sampled on start.
- query_enable  out  1  edge request to the edge cache.
- from_node  out  INDEX_WIDTH  always the latched `u`.
- to_node  out  INDEX_WIDTH  `v` under query.
- edge_ready  in  1  edge cache ready. Level signal, only meaningful while query_enable is high.
- edge_value  in  VALUE_WIDTH  weight. 0 = no edge.
- dist_addr  out  INDEX_WIDTH  distance table read/write address.
- dist_rd_data  in  VALUE_WIDTH  `dist[dist_addr]`. Valid 1 cycle after the address is presented.
- visited_rd  in  1  visited flag of `dist_addr`. Same 1-cycle latency.
- dist_wr_en  out  1  one-cycle write strobe.
- dist_wr_data  out  VALUE_WIDTH  new distance.
- prev_wr_data  out  INDEX_WIDTH  predecessor written alongside. Always the latched `u`.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the neighbour scan is complete.
- updates  out  INDEX_WIDTH  count of writes in the last run. Held until the next start.

Behaviour:
- Reset values:
  - State = IDLE.
  - query_enable, dist_wr_en, busy, done = 0.
  - from_node, to_node, dist_addr, dist_wr_data, prev_wr_data, updates = 0.
  - Reset mid-run aborts immediately. No further write is issued after the reset cycle.
- IDLE:
  - On start: latch `u`, `dist[u]` and N; set v = 0; clear updates; go to SELECT.
  - If N == 0, go straight to FINISH instead.
- SELECT:
  - If v == u, skip to NEXT. No query is made and no table access happens.
  - Otherwise drive dist_addr = v and go to QUERY.
- QUERY:
  - Assert query_enable with to_node = v and from_node = u.
  - Hold all three stable until edge_ready is sampled high.
  - Latch edge_value (w), then go to COMPARE.
  - Wait indefinitely; there is no timeout.
- COMPARE:
  - query_enable is low in this cycle. This gives at least one low cycle between consecutive queries, and the edge cache must drop ready while query_enable is low.
  - dist_rd_data and visited_rd are valid here, because the address was held since SELECT (at least 1 cycle).
  - Compute `sum = dist[u] + w` in VALUE_WIDTH+1 bits.
  - Improve when all of the following hold: w != 0, visited_rd == 0, `dist[u]` != all-ones, `sum[VALUE_WIDTH]` == 0, and `sum[VALUE_WIDTH-1:0] < dist_rd_data` (strictly less).
  - On improve: one-cycle dist_wr_en with dist_wr_data = sum, prev_wr_data = u, dist_addr = v; increment updates.
  - Go to NEXT.
- NEXT:
  - If v == N-1, go to FINISH. Otherwise v = v + 1 and go to SELECT.
  - v never wraps. A v of MAX_NODES-1 terminates the scan.
- FINISH:
  - Pulse done for 1 cycle; busy falls in the same cycle; return to IDLE.
  - start may be accepted in the cycle after done.
- Other rules:
  - A start that arrives while busy is dropped.
  - Equal distances do not overwrite, so the first-found predecessor is kept.
  - Latency per non-self node is 4 cycles plus the edge-cache wait. A self node costs 2 cycles.

Test Plan:
- N=4, u=0, `dist[u]`=0, weights {0,5,0,2}, table all-ones, unvisited -> writes (v=1, 5, prev 0) and (v=3, 2, prev 0); updates=2; exactly one done pulse; no query with to_node=0.
- u=2, `dist[u]`=10, w(2,1)=3, `dist[1]`=13 -> no write (equal). Then `dist[1]`=14 -> write 13.
- `dist[u]`=all-ones-1 (e.g. 8'hFE), w=5 -> overflow, no write. `dist[u]`=all-ones -> no writes for any edge.
- Visited v=1 with `dist[1]`=all-ones, w=1 -> no write. Edge cache delays ready by 7 cycles -> to_node held stable and a single query observed.
- Reset asserted in the cycle QUERY begins -> next cycle query_enable=0, busy=0, no dist_wr_en. A fresh start then completes normally.
- N=0 start -> done on the second cycle, no queries. A start pulsed while busy -> ignored, and updates reflects only the first run.
